dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single byte-addressed data memory between two requesters: requester 0 is the CPU load/store stage, requester 1 is the program/data loader.
- Arbitrates with round-robin or fixed priority. Registers the winning request and drives the memory port for exactly one cycle, then returns a one-cycle response.
- Sits between the requesters and the data memory. Uses the memory's 3-bit access-size encoding: [1:0] 00 byte, 01 half, 1x word; [2] set means unsigned load.

Parameters:
- A_WIDTH, 20, number of implemented memory address bits.
- FIXED_PRIO, 0, 0 selects round-robin; 1 selects requester 0 always winning.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_ready  out  2  per-requester accept.
- req_addr0, req_addr1  in  32 each  byte address.
- req_wdata0, req_wdata1  in  32 each  store data.
- req_we  in  2  per-requester write enable.
- req_size0, req_size1  in  3 each  access size, memory encoding.
- rsp_valid  out  2  one-cycle response strobe per requester.
- rsp_rdata  out  32  load data, shared by both requesters; qualified by rsp_valid.
- rsp_err  out  1  response is an error; qualified by rsp_valid.
- mem_A  out  32  memory address.
- mem_WD  out  32  memory write data.
- mem_WE  out  1  memory write enable.
- mem_MemSrc  out  3  memory access size.
- mem_RD  in  32  memory combinational read data.

Behaviour:
- Reset values: state IDLE; req_ready=0; rsp_valid=0; rsp_rdata=0; rsp_err=0; all mem_* outputs 0; last_grant=1, so requester 0 wins first.
- Reset asserted mid-operation: the in-flight transaction is dropped, no response is issued, and no memory write occurs after reset asserts.
- FSM IDLE -> ACCESS -> RESP -> IDLE; one transaction per 3 cycles.
- IDLE:
  - req_ready is asserted combinationally to the arbitration winner only. A requester with valid low never sees ready.
  - Round-robin (FIXED_PRIO=0): if both are valid, grant the requester not equal to last_grant. Fixed priority (FIXED_PRIO=1): requester 0 always wins.
  - On handshake: latch addr, wdata, we, size and owner; update last_grant to owner; go to ACCESS.
- ACCESS:
  - Drive mem_A, mem_WD, mem_MemSrc from the latched fields.
  - mem_WE = latched we, unless an error condition holds, in which case mem_WE=0.
  - Capture mem_RD into rsp_rdata (0 for writes and errors). Go to RESP.
  - Outside ACCESS, all mem_* outputs are 0.
- Error condition: latched addr[31:A_WIDTH] != 0 (out of range).
- RESP: rsp_valid[owner]=1 for exactly one cycle, together with rsp_rdata and rsp_err; then go to IDLE. Responses cannot be stalled.
- Latency: handshake in cycle N, memory access in N+1, response in N+2. Writes also respond, with an acknowledgement and rdata=0.
- Requester rules:
  - Request fields must be stable while valid is high and ready is low.
  - Dropping valid before ready is legal and produces no transaction.
  - A requester may re-request in the cycle after its rsp_valid.
- Starvation bound: in round-robin mode, a continuously valid requester is granted within 6 cycles.

Optional Feature:
- Macro DMEM_ARB_MISALIGN_TRAP_EN.
- Defined: a misaligned half access (addr[0]=1) or word access (addr[1:0]!=0) is an additional error condition. It is handled exactly like out-of-range: no write, rdata=0, rsp_err=1.
- Undefined: misaligned accesses pass through to the memory unchanged, and rsp_err reflects only out-of-range.

Test Plan:
- Req0 alone, write word 0xDEADBEEF to 0x10000, size 010 → memory written in N+1, rsp_valid=01 in N+2, rsp_err=0. Req0 then reads 0x10000, size 010 → rsp_rdata=0xDEADBEEF.
- Req0 and req1 both valid continuously after reset → grants alternate 0,1,0,1, one grant every 3 cycles. With FIXED_PRIO=1, req1 is never granted.
- Req1 writes to 0x00100000 (A_WIDTH=20) → mem_WE stays 0, rsp_valid=10, rsp_err=1, rsp_rdata=0.
- Memory byte 0x10004 preloaded with 0x80; read size 000 → 0xFFFFFF80; read size 100 → 0x00000080.
- rst_n pulled low during ACCESS of a write → no mem_WE pulse, no rsp_valid, outputs 0; first request after release is granted to requester 0.
- With DMEM_ARB_MISALIGN_TRAP_EN defined, word read at 0x10002 → rsp_err=1 and mem_WE=0. Without the macro, the same read → rsp_err=0 and the data is returned.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one byte-addressed data memory between requester 0 (CPU load/store
//   stage) and requester 1 (program/data loader). A winning request is latched
//   in IDLE, drives the memory port for exactly one cycle in ACCESS, and gets a
//   one-cycle response in RESP, so one transaction completes every 3 cycles.
//
//   Access size uses the memory encoding: [1:0] 00 byte, 01 half, 1x word;
//   [2] set means unsigned load. Sign/zero extension happens in the memory.
//
// Parameters
//   A_WIDTH     implemented memory address bits; any higher set bit is an error
//   FIXED_PRIO  0 round-robin, 1 requester 0 always wins
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready [1:0]  per-requester handshake (bit i = requester i)
//   req_addr*/req_wdata*       byte address / store data per requester
//   req_we [1:0], req_size*    write enable / access size per requester
//   rsp_valid [1:0]            one-cycle response strobe per requester
//   rsp_rdata, rsp_err         shared load data / error flag, qualified by rsp_valid
//   mem_A, mem_WD, mem_WE,
//   mem_MemSrc                 memory port, non-zero only during ACCESS
//   mem_RD                     combinational read data from memory
//
// Build option
//   DMEM_ARB_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses are
//                              treated like out-of-range ones (no write,
//                              rdata 0, rsp_err 1).
// -----------------------------------------------------------------------------
//  state  | meaning
//  IDLE   | arbitrate, ready to winner, latch request on handshake
//  ACCESS | drive memory port for one cycle, capture read data / error
//  RESP   | rsp_valid to owner for one cycle
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int A_WIDTH    = 20,
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  input  logic [1:0]  req_we,
  input  logic [2:0]  req_size0,
  input  logic [2:0]  req_size1,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  output logic [2:0]  mem_MemSrc,
  input  logic [31:0] mem_RD
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Address bits at or above A_WIDTH; evaluates to 0 when A_WIDTH is 32.
  localparam logic [31:0] HI_MASK = ~((32'h1 << A_WIDTH) - 32'h1);

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [2:0]  size_q;
  logic        owner_q;
  logic        last_grant_q;
  logic [1:0]  rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        grant_valid;
  logic        grant_sel;
  logic        in_access;
  logic        out_of_range;
  logic        misalign;
  logic        acc_err;

  // Winner among the valid requesters; with both valid, round-robin picks the
  // one that did not win last time.
  always_comb begin
    grant_valid = (req_valid != 2'b00);
    if (req_valid == 2'b11) begin
      grant_sel = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
    end else begin
      grant_sel = req_valid[1];
    end
  end

  always_comb begin
    req_ready = 2'b00;
    if (state_q == ST_IDLE && grant_valid) begin
      req_ready = grant_sel ? 2'b10 : 2'b01;
    end
  end

  assign out_of_range = |(addr_q & HI_MASK);

`ifdef DMEM_ARB_MISALIGN_TRAP_EN
  assign misalign = size_q[1] ? (addr_q[1:0] != 2'b00) : (size_q[0] & addr_q[0]);
`else
  assign misalign = 1'b0;
`endif

  assign acc_err   = out_of_range | misalign;
  assign in_access = (state_q == ST_ACCESS);

  assign mem_A      = in_access ? addr_q  : 32'h0;
  assign mem_WD     = in_access ? wdata_q : 32'h0;
  assign mem_MemSrc = in_access ? size_q  : 3'b000;
  assign mem_WE     = in_access & we_q & ~acc_err;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_valid) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      we_q         <= 1'b0;
      size_q       <= 3'b000;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= 32'h0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            owner_q      <= grant_sel;
            last_grant_q <= grant_sel;
            addr_q       <= grant_sel ? req_addr1  : req_addr0;
            wdata_q      <= grant_sel ? req_wdata1 : req_wdata0;
            we_q         <= req_we[grant_sel];
            size_q       <= grant_sel ? req_size1  : req_size0;
          end
        end
        ST_ACCESS: begin
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          rsp_err_q   <= acc_err;
          rsp_rdata_q <= (we_q | acc_err) ? 32'h0 : mem_RD;
        end
        ST_RESP: begin
          rsp_valid_q <= 2'b00;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= 32'h0;
        end
        default: begin
          rsp_valid_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int A_WIDTH    = 20;
  localparam int FIXED_PRIO = 0;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [1:0]  req_we;
  logic [2:0]  req_size0, req_size1;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_A, mem_WD;
  logic        mem_WE;
  logic [2:0]  mem_MemSrc;
  logic [31:0] mem_RD;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.A_WIDTH(A_WIDTH), .FIXED_PRIO(FIXED_PRIO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_we(req_we), .req_size0(req_size0), .req_size1(req_size1),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE),
    .mem_MemSrc(mem_MemSrc), .mem_RD(mem_RD)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Data memory seen by the DUT: 256-byte window, little endian, does the
  // sign/zero extension for sub-word loads.
  bit   [7:0] dmem [256];
  logic [7:0] rb0, rb1, rb2, rb3;

  always_comb begin
    rb0 = dmem[mem_A[7:0]];
    rb1 = dmem[mem_A[7:0] + 8'd1];
    rb2 = dmem[mem_A[7:0] + 8'd2];
    rb3 = dmem[mem_A[7:0] + 8'd3];
    case (mem_MemSrc[1:0])
      2'b00:   mem_RD = {{24{rb0[7] & ~mem_MemSrc[2]}}, rb0};
      2'b01:   mem_RD = {{16{rb1[7] & ~mem_MemSrc[2]}}, rb1, rb0};
      default: mem_RD = {rb3, rb2, rb1, rb0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_WE) begin
      dmem[mem_A[7:0]] <= mem_WD[7:0];
      if (mem_MemSrc[1:0] != 2'b00) dmem[mem_A[7:0] + 8'd1] <= mem_WD[15:8];
      if (mem_MemSrc[1]) begin
        dmem[mem_A[7:0] + 8'd2] <= mem_WD[23:16];
        dmem[mem_A[7:0] + 8'd3] <= mem_WD[31:24];
      end
    end
  end

  // Reference model: byte array updated per completed transaction.
  bit [7:0] ref_mem [256];

  function automatic int ref_bytes(input logic [2:0] s);
    return s[1] ? 4 : (s[0] ? 2 : 1);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] s);
    logic [31:0] v;
    int n;
    n = ref_bytes(s);
    v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[8'(a + 32'(k))];
    if (!s[2] && n < 4 && v[8*n-1]) begin
      for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    end
    return v;
  endfunction

  function automatic void ref_store(input logic [31:0] a, input logic [31:0] w, input logic [2:0] s);
    for (int k = 0; k < ref_bytes(s); k++) ref_mem[8'(a + 32'(k))] = w[8*k +: 8];
  endfunction

  function automatic bit ref_err(input logic [31:0] a, input logic [2:0] s);
    bit e;
    e = ((a >> A_WIDTH) != 32'h0);
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    if (ref_bytes(s) > 1 && (a % ref_bytes(s)) != 0) e = 1'b1;
`endif
    return e;
  endfunction

  task automatic set_req(input int who, input logic [31:0] a, input logic [31:0] w,
                         input logic we, input logic [2:0] s);
    if (who == 0) begin
      req_addr0 = a; req_wdata0 = w; req_we[0] = we; req_size0 = s;
    end else begin
      req_addr1 = a; req_wdata1 = w; req_we[1] = we; req_size1 = s;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Starts and ends 1 time unit after a rising edge with the DUT in IDLE.
  task automatic do_txn(input int who, input logic [31:0] a, input logic [31:0] w,
                        input logic we, input logic [2:0] s,
                        output bit granted, output logic acc_we, output logic [31:0] acc_a,
                        output logic [1:0] rv, output logic [31:0] rd, output logic er);
    int n;
    set_req(who, a, w, we, s);
    req_valid[who] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[who] && n < 10) begin
      @(posedge clk); #2;
      n++;
    end
    granted = req_ready[who];
    acc_we = 1'bx; acc_a = 'x; rv = 'x; rd = 'x; er = 1'bx;
    if (!granted) begin
      req_valid[who] = 1'b0;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    req_valid[who] = 1'b0;
    acc_we = mem_WE;
    acc_a  = mem_A;
    @(posedge clk); #1;
    rv = rsp_valid; rd = rsp_rdata; er = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    set_req(0, 32'h0, 32'h0, 1'b0, 3'b000);
    set_req(1, 32'h0, 32'h0, 1'b0, 3'b000);
    #12;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp got=%h/%b exp=0/0", rsp_rdata, rsp_err); end
    checks++; if ({mem_A, mem_WD, mem_WE, mem_MemSrc} !== 68'h0) begin errors++; $display("FAIL reset_mem got A=%h WD=%h WE=%b S=%b exp=0", mem_A, mem_WD, mem_WE, mem_MemSrc); end
    @(posedge clk); #1 rst_n = 1'b1;
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_grant got=%b exp=01", req_ready); end
    // Withdraw before the edge: no transaction, arbitration state unchanged.
    req_valid = 2'b00;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL ready_without_valid got=%b exp=00", req_ready); end
    repeat (3) @(posedge clk);
    #2;
    checks++; if (rsp_valid !== 2'b00 || mem_WE !== 1'b0) begin errors++; $display("FAIL dropped_request got rv=%b we=%b exp=00/0", rsp_valid, mem_WE); end
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL grant_after_drop got=%b exp=01", req_ready); end
    req_valid = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    bit g; logic awe; logic [31:0] aa, rd; logic [1:0] rv; logic er;
    do_txn(0, 32'h0001_0000, 32'hDEAD_BEEF, 1'b1, 3'b010, g, awe, aa, rv, rd, er);
    ref_store(32'h0001_0000, 32'hDEAD_BEEF, 3'b010);
    checks++; if (!g || awe !== 1'b1 || aa !== 32'h0001_0000) begin errors++; $display("FAIL wr_access got g=%0d we=%b A=%h exp 1/1/00010000", g, awe, aa); end
    checks++; if (rv !== 2'b01 || er !== 1'b0) begin errors++; $display("FAIL wr_resp got rv=%b err=%b exp=01/0", rv, er); end
    do_txn(0, 32'h0001_0000, 32'h0, 1'b0, 3'b010, g, awe, aa, rv, rd, er);
    checks++; if (rv !== 2'b01 || rd !== 32'hDEAD_BEEF || awe !== 1'b0) begin errors++; $display("FAIL rd_word got rv=%b rd=%h we=%b exp=01/deadbeef/0", rv, rd, awe); end
  endtask

  task automatic test_sign_ext();
    bit g; logic awe; logic [31:0] aa, rd; logic [1:0] rv; logic er;
    do_txn(1, 32'h0001_0004, 32'h0000_0080, 1'b1, 3'b000, g, awe, aa, rv, rd, er);
    ref_store(32'h0001_0004, 32'h0000_0080, 3'b000);
    checks++; if (rv !== 2'b10 || er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL wr_byte got rv=%b err=%b rd=%h exp=10/0/0", rv, er, rd); end
    do_txn(0, 32'h0001_0004, 32'h0, 1'b0, 3'b000, g, awe, aa, rv, rd, er);
    checks++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL rd_byte_signed got=%h exp=ffffff80", rd); end
    do_txn(1, 32'h0001_0004, 32'h0, 1'b0, 3'b100, g, awe, aa, rv, rd, er);
    checks++; if (rd !== 32'h0000_0080 || rv !== 2'b10) begin errors++; $display("FAIL rd_byte_unsigned got rd=%h rv=%b exp=00000080/10", rd, rv); end
  endtask

  task automatic test_out_of_range();
    bit g; logic awe; logic [31:0] aa, rd; logic [1:0] rv; logic er;
    do_txn(1, 32'h0010_0000, 32'h1234_5678, 1'b1, 3'b010, g, awe, aa, rv, rd, er);
    checks++; if (awe !== 1'b0) begin errors++; $display("FAIL oor_write_we got=%b exp=0", awe); end
    checks++; if (rv !== 2'b10 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL oor_resp got rv=%b err=%b rd=%h exp=10/1/0", rv, er, rd); end
    // The rejected write must not have landed in the aliased low bytes.
    do_txn(0, 32'h0001_0000, 32'h0, 1'b0, 3'b010, g, awe, aa, rv, rd, er);
    checks++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin errors++; $display("FAIL oor_no_alias got rd=%h err=%b exp=deadbeef/0", rd, er); end
  endtask

  task automatic test_misalign();
    bit g; logic awe; logic [31:0] aa, rd; logic [1:0] rv; logic er;
    logic [31:0] exp_rd; logic exp_er;
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    exp_er = 1'b1; exp_rd = 32'h0;
`else
    exp_er = 1'b0; exp_rd = 32'h0080_DEAD;
`endif
    do_txn(0, 32'h0001_0002, 32'h0, 1'b0, 3'b010, g, awe, aa, rv, rd, er);
    checks++; if (er !== exp_er || rd !== exp_rd || awe !== 1'b0) begin errors++; $display("FAIL misalign_word got err=%b rd=%h we=%b exp=%b/%h/0", er, rd, awe, exp_er, exp_rd); end
  endtask

  task automatic test_round_robin();
    int gcyc [4]; logic [1:0] gwho [4]; logic [1:0] rvh [16];
    int ng; int last; int w;
    apply_reset();
    set_req(0, 32'h0001_0000, 32'h0, 1'b0, 3'b010);
    set_req(1, 32'h0001_0004, 32'h0, 1'b0, 3'b010);
    req_valid = 2'b11;
    #1;
    ng = 0;
    for (int c = 0; c < 16; c++) begin
      rvh[c] = rsp_valid;
      if (req_ready != 2'b00 && ng < 4) begin
        gcyc[ng] = c; gwho[ng] = req_ready; ng++;
      end
      @(posedge clk); #2;
    end
    req_valid = 2'b00;
    @(posedge clk); #1;
    checks++; if (ng !== 4) begin errors++; $display("FAIL rr_grant_count got=%0d exp=4", ng); end
    last = 1;
    for (int i = 0; i < ng; i++) begin
      w = (FIXED_PRIO != 0) ? 0 : 1 - last;
      last = w;
      checks++; if (gwho[i] !== (2'b01 << w)) begin errors++; $display("FAIL rr_grant_%0d got=%b exp=%b", i, gwho[i], 2'b01 << w); end
      checks++; if (rvh[gcyc[i] + 2] !== (2'b01 << w)) begin errors++; $display("FAIL rr_resp_%0d got=%b exp=%b", i, rvh[gcyc[i] + 2], 2'b01 << w); end
      if (i > 0) begin
        checks++; if (gcyc[i] - gcyc[i-1] !== 3) begin errors++; $display("FAIL rr_spacing_%0d got=%0d exp=3", i, gcyc[i] - gcyc[i-1]); end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    bit g; logic awe; logic [31:0] aa, rd; logic [1:0] rv; logic er;
    logic [31:0] exp_rd;
    set_req(0, 32'h0001_0008, 32'h1234_5678, 1'b1, 3'b010);
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_rst_ready got=%b exp=01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    checks++; if (mem_WE !== 1'b1) begin errors++; $display("FAIL mid_rst_access_we got=%b exp=1", mem_WE); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_WE !== 1'b0 || mem_A !== 32'h0 || rsp_valid !== 2'b00) begin errors++; $display("FAIL mid_rst_outputs got we=%b A=%h rv=%b exp=0/0/00", mem_WE, mem_A, rsp_valid); end
    @(posedge clk); #1;
    checks++; if (mem_WE !== 1'b0 || rsp_valid !== 2'b00 || rsp_err !== 1'b0) begin errors++; $display("FAIL mid_rst_hold got we=%b rv=%b err=%b exp=0/00/0", mem_WE, rsp_valid, rsp_err); end
    @(posedge clk); #1 rst_n = 1'b1;
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_rst_first_grant got=%b exp=01", req_ready); end
    req_valid = 2'b00;
    @(posedge clk); #1;
    exp_rd = ref_load(32'h0001_0008, 3'b010);
    do_txn(1, 32'h0001_0008, 32'h0, 1'b0, 3'b010, g, awe, aa, rv, rd, er);
    checks++; if (rd !== exp_rd || rv !== 2'b10) begin errors++; $display("FAIL mid_rst_no_write got rd=%h rv=%b exp=%h/10", rd, rv, exp_rd); end
  endtask

  task automatic test_random();
    bit g; logic awe; logic [31:0] aa, rd; logic [1:0] rv; logic er;
    int who; logic we; logic [2:0] s; logic [31:0] a, w, exp_rd; bit e;
    for (int i = 0; i < 60; i++) begin
      who = $urandom_range(0, 1);
      we  = 1'($urandom_range(0, 1));
      s   = 3'($urandom_range(0, 7));
      a   = 32'h0001_0000 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) a = a | (32'h1 << $urandom_range(A_WIDTH, 31));
      w   = $urandom;
      e   = ref_err(a, s);
      exp_rd = (e || we) ? 32'h0 : ref_load(a, s);
      do_txn(who, a, w, we, s, g, awe, aa, rv, rd, er);
      if (!e && we) ref_store(a, w, s);
      checks++; if (!g) begin errors++; $display("FAIL rnd_%0d_grant got=0 exp=1", i); end
      checks++; if (rv !== (2'b01 << who) || er !== e) begin errors++; $display("FAIL rnd_%0d_resp got rv=%b err=%b exp=%b/%b", i, rv, er, 2'b01 << who, e); end
      checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd_%0d_rdata a=%h s=%b got=%h exp=%h", i, a, s, rd, exp_rd); end
      checks++; if (awe !== (we & ~e) || aa !== a) begin errors++; $display("FAIL rnd_%0d_mem got we=%b A=%h exp=%b/%h", i, awe, aa, we & ~e, a); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_sign_ext();
    test_out_of_range();
    test_misalign();
    test_reset_mid_access();
    test_round_robin();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
